// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: next-PC operation
// encodings, instruction-field widths and small decode helpers.
package pc_gen_pkg;

    // Width of the NPCOp field driven by the controller.
    localparam int NPC_OP_W = 3;

    // Width of the instruction immediate / jump index field.
    localparam int IMM_W = 26;

    // Width of the branch displacement taken from the low immediate bits.
    localparam int BR_IMM_W = 16;

    // Next-PC operations. Code 3'b111 is reserved and behaves as PLUS4
    // without touching the return-address stack.
    typedef enum logic [NPC_OP_W-1:0] {
        NPC_PLUS4  = 3'b000,
        NPC_BRANCH = 3'b001,
        NPC_JUMP   = 3'b010,
        NPC_JUMPR  = 3'b011,
        NPC_CALL   = 3'b100,
        NPC_CALLR  = 3'b101,
        NPC_RET    = 3'b110,
        NPC_RSVD   = 3'b111
    } npc_op_e;

    // Operations that push their link address onto the return stack.
    function automatic logic is_call(input npc_op_e op);
        return (op == NPC_CALL) || (op == NPC_CALLR);
    endfunction

    // Operations that pop the return stack.
    function automatic logic is_ret(input npc_op_e op);
        return (op == NPC_RET);
    endfunction

endpackage : pc_gen_pkg

// File: rtl/pc_gen_if.sv
// Controller <-> PC generator bundle. The controller side (master) drives
// the control-flow request; the PC generator (slave) returns the PC state
// and the return-stack debug indicators.
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);

    // Requests from the controller / datapath
    logic                stall;
    logic [NPC_OP_W-1:0] NPCOp;
    logic [IMM_W-1:0]    IMM;
    logic [WIDTH-1:0]    Reg;
    logic                exc;
    logic                eret;

    // PC state returned to instruction memory and the controller
    logic [WIDTH-1:0]    PC;
    logic [WIDTH-1:0]    NPC;
    logic [WIDTH-1:0]    EPC;

    // Return-stack debug indicators
    logic                ras_empty;
    logic                ras_ovf;
    logic                ras_unf;
    logic                ras_mismatch;
    logic [CNT_W-1:0]    mismatch_cnt;

    modport master (
        output stall, NPCOp, IMM, Reg, exc, eret,
        input  PC, NPC, EPC,
        input  ras_empty, ras_ovf, ras_unf, ras_mismatch, mismatch_cnt
    );

    modport slave (
        input  stall, NPCOp, IMM, Reg, exc, eret,
        output PC, NPC, EPC,
        output ras_empty, ras_ovf, ras_unf, ras_mismatch, mismatch_cnt
    );

endinterface : pc_gen_if

// File: rtl/pc_ras.sv
// Circular return-address stack used to track call/return pairing for
// debug. The pointer addresses the next free slot, so the top entry sits
// one below it. A push into a full stack wraps onto the oldest entry; a pop
// from an empty stack leaves the state alone. Both events raise sticky flags
// that only reset clears.
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_ovf,
    output logic             o_unf
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;
    logic [PTR_W-1:0] w_top_idx;

    // Depth is a power of two, so the pointer wraps on its own.
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(RAS_DEPTH));
    assign o_top     = r_stack[w_top_idx];
    assign o_ovf     = r_ovf;
    assign o_unf     = r_unf;

    // Pointer, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rstn) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (i_push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (o_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_pop) begin
            if (o_empty) begin
                r_unf <= 1'b1;
            end else begin
                r_ptr   <= w_top_idx;
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Stack storage write on push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; an entry is only meaningful
        // while the occupancy count covers it, and consumers mask it with
        // o_empty.
        if (i_push) begin
            r_stack[r_ptr] <= i_push_data;
        end
    end

endmodule : pc_ras

// File: rtl/pc_gen.sv
// Registered program-counter generator. Computes the next PC for every
// control-flow operation, handles exception entry/return with an internal
// EPC, and checks RET targets against a return-address stack, counting
// mismatching returns. The stack is advisory: a RET always goes to Reg.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
    parameter int               RAS_DEPTH = 4,
    parameter int               CNT_W     = 16
) (
    input  logic    clk,
    input  logic    rstn,
    pc_gen_if.slave pc_bus
);

    npc_op_e          w_op;
    logic [WIDTH-1:0] w_pcplus4;
    logic [WIDTH-1:0] w_br_off;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_npc;
    logic             w_commit;
    logic             w_push;
    logic             w_pop;
    logic             w_mismatch;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_empty;
    logic             w_ras_full;
    logic             w_ras_ovf;
    logic             w_ras_unf;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [CNT_W-1:0] r_mismatch_cnt;

    assign w_op      = npc_op_e'(pc_bus.NPCOp);
    assign w_pcplus4 = r_pc + WIDTH'(4);

    // Sign-extended word displacement: sext(IMM[15:0]) << 2.
    assign w_br_off = {{(WIDTH - BR_IMM_W - 2){pc_bus.IMM[BR_IMM_W-1]}},
                       pc_bus.IMM[BR_IMM_W-1:0], 2'b00};

    // Control-flow target selected by NPCOp, before exception/stall override.
    always_comb begin
        // NOTE: a default assigned first guarantees every path drives the
        // output, so no latch is inferred for unlisted cases.
        w_target = w_pcplus4;
        unique case (w_op)
            NPC_PLUS4:  w_target = w_pcplus4;
            NPC_BRANCH: w_target = w_pcplus4 + w_br_off;
            NPC_JUMP,
            NPC_CALL:   w_target = {w_pcplus4[WIDTH-1:28], pc_bus.IMM, 2'b00};
            NPC_JUMPR,
            NPC_CALLR,
            NPC_RET:    w_target = pc_bus.Reg;
            NPC_RSVD:   w_target = w_pcplus4;
        endcase
    end

    // Final next-PC with priority exc > eret > stall > NPCOp.
    always_comb begin
        w_npc = w_target;
        if (pc_bus.exc) begin
            w_npc = EXC_VEC;
        end else if (pc_bus.eret) begin
            w_npc = r_epc;
        end else if (pc_bus.stall) begin
            w_npc = r_pc;
        end
    end

    // Only an unstalled, non-exceptional cycle commits stack and counter side effects.
    assign w_commit   = !pc_bus.exc && !pc_bus.eret && !pc_bus.stall;
    assign w_push     = w_commit && is_call(w_op);
    assign w_pop      = w_commit && is_ret(w_op);
    assign w_mismatch = is_ret(w_op) && (w_ras_empty || (w_ras_top != pc_bus.Reg));

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pcplus4),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_full      (w_ras_full),
        .o_ovf       (w_ras_ovf),
        .o_unf       (w_ras_unf)
    );

    // PC register: always loads NPC, which already folds in the stall hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_npc;
        end
    end

    // EPC captures the interrupted PC on exception entry only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_epc <= '0;
        end else if (pc_bus.exc) begin
            r_epc <= r_pc;
        end
    end

    // Saturating count of committed RETs whose target disagreed with the stack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mismatch_cnt <= '0;
        end else if (w_commit && w_mismatch && (r_mismatch_cnt != '1)) begin
            r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
        end
    end

    assign pc_bus.PC           = r_pc;
    assign pc_bus.NPC          = w_npc;
    assign pc_bus.EPC          = r_epc;
    assign pc_bus.ras_empty    = w_ras_empty;
    assign pc_bus.ras_ovf      = w_ras_ovf;
    assign pc_bus.ras_unf      = w_ras_unf;
    assign pc_bus.ras_mismatch = w_mismatch;
    assign pc_bus.mismatch_cnt = r_mismatch_cnt;

    // Full is implied by the overflow flag at this level; keep it observable
    // to the stack only.
    logic w_unused;
    assign w_unused = w_ras_full;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: a table of single-cycle vectors with hand-derived PCs,
// a behavioural model feeding a scoreboard queue of post-edge state, and
// hand-written sequences for reset, stack overflow/underflow, exceptions
// and stalled calls.
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam int          WIDTH     = 32;
    localparam int          CNT_W     = 16;
    localparam int          RAS_DEPTH = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_4180;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    pc_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    pc_gen #(
        .WIDTH     (WIDTH),
        .RESET_PC  (RESET_PC),
        .EXC_VEC   (EXC_VEC),
        .RAS_DEPTH (RAS_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .pc_bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_ras[$];
    logic        m_ovf;
    logic        m_unf;
    logic [15:0] m_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        empty;
        logic        ovf;
        logic        unf;
        logic [15:0] cnt;
    } state_t;

    state_t sb_q[$];

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_epc = 32'h0;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_cnt = 16'h0;
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, push the
    // expected post-edge state, then pop and compare just after the edge.
    task automatic step(input logic stall, input logic [2:0] op, input logic [25:0] imm,
                        input logic [31:0] rg, input logic exc, input logic eret,
                        input string tag, output logic obs_mm);
        logic [31:0] plus4, tgt, e_npc, off;
        logic        e_mm, commit;
        state_t      e, got;

        bus.stall = stall;
        bus.NPCOp = op;
        bus.IMM   = imm;
        bus.Reg   = rg;
        bus.exc   = exc;
        bus.eret  = eret;

        plus4 = m_pc + 32'd4;
        off   = {{14{imm[15]}}, imm[15:0], 2'b00};
        case (op)
            3'b001:                 tgt = plus4 + off;
            3'b010, 3'b100:         tgt = {plus4[31:28], imm, 2'b00};
            3'b011, 3'b101, 3'b110: tgt = rg;
            default:                tgt = plus4;
        endcase
        if (exc)        e_npc = EXC_VEC;
        else if (eret)  e_npc = m_epc;
        else if (stall) e_npc = m_pc;
        else            e_npc = tgt;
        e_mm   = (op == 3'b110) && ((m_ras.size() == 0) || (m_ras[m_ras.size()-1] != rg));
        commit = !exc && !eret && !stall;

        #4;
        check({tag, " NPC"}, bus.NPC, e_npc);
        check({tag, " ras_mismatch"}, 32'(bus.ras_mismatch), 32'(e_mm));
        obs_mm = bus.ras_mismatch;

        if (exc) m_epc = m_pc;
        if (commit) begin
            if (op == 3'b100 || op == 3'b101) begin
                m_ras.push_back(plus4);
                if (m_ras.size() > RAS_DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
            end else if (op == 3'b110) begin
                if (m_ras.size() == 0) m_unf = 1'b1;
                else void'(m_ras.pop_back());
            end
            if (e_mm && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        m_pc = e_npc;
        e.pc = m_pc; e.epc = m_epc; e.empty = (m_ras.size() == 0);
        e.ovf = m_ovf; e.unf = m_unf; e.cnt = m_cnt;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({tag, " PC"}, bus.PC, got.pc);
        check({tag, " EPC"}, bus.EPC, got.epc);
        check({tag, " ras_empty"}, 32'(bus.ras_empty), 32'(got.empty));
        check({tag, " ras_ovf"}, 32'(bus.ras_ovf), 32'(got.ovf));
        check({tag, " ras_unf"}, 32'(bus.ras_unf), 32'(got.unf));
        check({tag, " mismatch_cnt"}, 32'(bus.mismatch_cnt), 32'(got.cnt));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        stall;
        logic [2:0]  op;
        logic [25:0] imm;
        logic [31:0] rg;
        logic        exc;
        logic        eret;
        logic [31:0] exp_pc;
        logic        exp_mm;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic mm;

        //          stall op      imm           rg            exc   eret  exp_pc        exp_mm
        vecs[0]  = '{1'b0, 3'b000, 26'h0,       32'h0,        1'b0, 1'b0, 32'h0000_3004, 1'b0};
        vecs[1]  = '{1'b0, 3'b000, 26'h0,       32'h0,        1'b0, 1'b0, 32'h0000_3008, 1'b0};
        vecs[2]  = '{1'b0, 3'b000, 26'h0,       32'h0,        1'b0, 1'b0, 32'h0000_300C, 1'b0};
        vecs[3]  = '{1'b0, 3'b000, 26'h0,       32'h0,        1'b0, 1'b0, 32'h0000_3010, 1'b0};
        vecs[4]  = '{1'b0, 3'b001, 26'h000FFFC, 32'h0,        1'b0, 1'b0, 32'h0000_3004, 1'b0};
        vecs[5]  = '{1'b0, 3'b010, 26'h0000C40, 32'h0,        1'b0, 1'b0, 32'h0000_3100, 1'b0};
        vecs[6]  = '{1'b0, 3'b011, 26'h0,       32'h0000_3000, 1'b0, 1'b0, 32'h0000_3000, 1'b0};
        vecs[7]  = '{1'b0, 3'b100, 26'h0000C40, 32'h0,        1'b0, 1'b0, 32'h0000_3100, 1'b0};
        vecs[8]  = '{1'b0, 3'b110, 26'h0,       32'h0000_3004, 1'b0, 1'b0, 32'h0000_3004, 1'b0};
        vecs[9]  = '{1'b0, 3'b110, 26'h0,       32'h0000_3004, 1'b0, 1'b0, 32'h0000_3004, 1'b1};
        vecs[10] = '{1'b0, 3'b001, 26'h0000010, 32'h0,        1'b0, 1'b0, 32'h0000_3048, 1'b0};
        vecs[11] = '{1'b0, 3'b111, 26'h3FFFFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_304C, 1'b0};
        vecs[12] = '{1'b0, 3'b101, 26'h0,       32'h0000_5000, 1'b0, 1'b0, 32'h0000_5000, 1'b0};
        vecs[13] = '{1'b0, 3'b110, 26'h0,       32'h0000_1234, 1'b0, 1'b0, 32'h0000_1234, 1'b1};
        vecs[14] = '{1'b1, 3'b000, 26'h0,       32'h0,        1'b0, 1'b0, 32'h0000_1234, 1'b0};
        vecs[15] = '{1'b1, 3'b000, 26'h0,       32'h0,        1'b1, 1'b0, 32'h0000_4180, 1'b0};
        vecs[16] = '{1'b0, 3'b000, 26'h0,       32'h0,        1'b0, 1'b1, 32'h0000_1234, 1'b0};
        vecs[17] = '{1'b1, 3'b110, 26'h0,       32'h0000_9999, 1'b0, 1'b0, 32'h0000_1234, 1'b1};

        // Reset state, checked between edges while rstn is low.
        bus.stall = 1'b0; bus.NPCOp = 3'b000; bus.IMM = '0; bus.Reg = '0;
        bus.exc = 1'b0; bus.eret = 1'b0;
        model_reset();
        #12;
        check("reset PC", bus.PC, RESET_PC);
        check("reset EPC", bus.EPC, 32'h0);
        check("reset NPC", bus.NPC, 32'h0000_3004);
        check("reset ras_empty", 32'(bus.ras_empty), 32'h1);
        check("reset ras_ovf", 32'(bus.ras_ovf), 32'h0);
        check("reset ras_unf", 32'(bus.ras_unf), 32'h0);
        check("reset mismatch_cnt", 32'(bus.mismatch_cnt), 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].stall, vecs[i].op, vecs[i].imm, vecs[i].rg,
                 vecs[i].exc, vecs[i].eret, $sformatf("vec%0d", i), mm);
            check($sformatf("vec%0d table PC", i), bus.PC, vecs[i].exp_pc);
            check($sformatf("vec%0d table mismatch", i), 32'(mm), 32'(vecs[i].exp_mm));
        end
        check("table mismatch_cnt", 32'(bus.mismatch_cnt), 32'd2);
        check("table EPC", bus.EPC, 32'h0000_1234);

        // Asynchronous reset mid-run: no clock edge between assert and check.
        #3;
        rstn = 1'b0;
        #1;
        check("async reset PC", bus.PC, RESET_PC);
        check("async reset EPC", bus.EPC, 32'h0);
        check("async reset ras_unf", 32'(bus.ras_unf), 32'h0);
        check("async reset ras_ovf", 32'(bus.ras_ovf), 32'h0);
        check("async reset mismatch_cnt", 32'(bus.mismatch_cnt), 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 26'h0, 32'h0, 1'b0, 1'b0, "post-reset plus4", mm);
        check("post-reset PC", bus.PC, 32'h0000_300C);

        // Five calls into a four-deep stack: the oldest link is overwritten.
        for (int i = 0; i < 5; i++)
            step(1'b0, 3'b101, 26'h0, 32'h0000_6000 + 32'(i) * 32'h100, 1'b0, 1'b0, "ovf call", mm);
        check("ovf flag", 32'(bus.ras_ovf), 32'h1);
        check("ovf PC", bus.PC, 32'h0000_6400);
        for (int i = 4; i >= 1; i--) begin
            step(1'b0, 3'b110, 26'h0, 32'h0000_6004 + 32'(i - 1) * 32'h100, 1'b0, 1'b0, "ovf ret", mm);
            check("ovf ret matches", 32'(mm), 32'h0);
        end
        check("ovf drained empty", 32'(bus.ras_empty), 32'h1);
        check("ovf no unf yet", 32'(bus.ras_unf), 32'h0);
        step(1'b0, 3'b110, 26'h0, 32'h0000_3010, 1'b0, 1'b0, "unf ret", mm);
        check("unf ret mismatch", 32'(mm), 32'h1);
        check("unf flag", 32'(bus.ras_unf), 32'h1);
        check("unf cnt", 32'(bus.mismatch_cnt), 32'h1);

        // Exception under stall, return, then exc and eret together.
        step(1'b0, 3'b011, 26'h0, 32'h0000_3008, 1'b0, 1'b0, "to 3008", mm);
        step(1'b1, 3'b000, 26'h0, 32'h0, 1'b1, 1'b0, "exc stalled", mm);
        check("exc PC", bus.PC, EXC_VEC);
        check("exc EPC", bus.EPC, 32'h0000_3008);
        step(1'b0, 3'b000, 26'h0, 32'h0, 1'b0, 1'b1, "eret", mm);
        check("eret PC", bus.PC, 32'h0000_3008);
        step(1'b0, 3'b011, 26'h0, 32'h0000_4184, 1'b0, 1'b0, "to 4184", mm);
        step(1'b0, 3'b000, 26'h0, 32'h0, 1'b1, 1'b1, "exc+eret", mm);
        check("exc+eret PC", bus.PC, EXC_VEC);
        check("exc+eret EPC", bus.EPC, 32'h0000_4184);

        // CALL held by stall for three cycles pushes exactly once.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b100, 26'h0000C40, 32'h0, 1'b0, 1'b0, "stalled call", mm);
            check("stalled call PC", bus.PC, EXC_VEC);
            check("stalled call empty", 32'(bus.ras_empty), 32'h1);
        end
        step(1'b0, 3'b100, 26'h0000C40, 32'h0, 1'b0, 1'b0, "call", mm);
        check("call PC", bus.PC, 32'h0000_3100);
        step(1'b0, 3'b110, 26'h0, 32'h0000_4184, 1'b0, 1'b0, "ret after call", mm);
        check("ret after call mismatch", 32'(mm), 32'h0);
        check("ret after call PC", bus.PC, 32'h0000_4184);
        step(1'b0, 3'b110, 26'h0, 32'h0000_4184, 1'b0, 1'b0, "second ret", mm);
        check("second ret mismatch", 32'(mm), 32'h1);
        check("second ret cnt", 32'(bus.mismatch_cnt), 32'h2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pc_gen
